dmem_arbiter: RTL and testbench

Shares the single-port data memory between the CPU data path (load/store traffic from the memory/IO address decoder) and the UART program loader. Issues at most one memory access per cycle, tracks the owner of the outstanding read so the response returns to the right requester, and sequences the boot-mode hand-over during which the loader has exclusive access and the CPU is stalled.

---
 rtl/dmem_arbiter_pkg.sv | 22 ++
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter.sv | 128 ++++++++++++
 tb/tb_dmem_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: widths, FSM state
// encoding, port-owner encoding and a saturating counter helper.
package dmem_arbiter_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    typedef logic [1:0] state_t;
    localparam state_t ST_RUN   = 2'd0;
    localparam state_t ST_DRAIN = 2'd1;
    localparam state_t ST_BOOT  = 2'd2;
    localparam state_t ST_EXIT  = 2'd3;

    typedef logic owner_t;
    localparam owner_t OWN_CPU = 1'b0;
    localparam owner_t OWN_LDR = 1'b1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The master side is the environment (CPU, loader, memory); the slave side
// is the arbiter itself.
interface dmem_arbiter_if;
    import dmem_arbiter_pkg::*;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_gnt;
    logic              ldr_rvalid;
    logic [DATA_W-1:0] ldr_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_gnt, ldr_rvalid, ldr_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_gnt, ldr_rvalid, ldr_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU data path and the UART
// program loader. One access per cycle, alternating priority on contention,
// read responses steered back to their owner, and a RUN/DRAIN/BOOT/EXIT
// hand-over that gives the loader exclusive access while the CPU is stalled.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
(
    input  logic           clock,
    input  logic           rst_n,
    input  logic           boot_mode,
    dmem_arbiter_if.slave  bus,
    output logic [15:0]    ldr_wr_count,
    output logic           boot_active
);

    state_t state;
    state_t state_next;
    owner_t last_winner;
    owner_t rd_owner;
    logic   rd_pending;
    logic   cpu_win;
    logic   ldr_win;
    logic   rd_issue;

    // Pick at most one winner from this cycle's requests and the current state
    always_comb begin
        cpu_win = 1'b0;
        ldr_win = 1'b0;
        case (state)
            ST_RUN: begin
                if (bus.cpu_req && bus.ldr_req) begin
                    if (last_winner == OWN_LDR) begin
                        cpu_win = 1'b1;
                    end else begin
                        ldr_win = 1'b1;
                    end
                end else begin
                    cpu_win = bus.cpu_req;
                    ldr_win = bus.ldr_req;
                end
            end
            ST_BOOT: begin
                ldr_win = bus.ldr_req;
            end
            default: begin
                cpu_win = 1'b0;
                ldr_win = 1'b0;
            end
        endcase
    end

    // Steer the winning port onto the memory bus; idle bus is all zeros
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (cpu_win) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.cpu_we;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (ldr_win) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.ldr_we;
            bus.mem_addr  = bus.ldr_addr;
            bus.mem_wdata = bus.ldr_wdata;
        end
    end

    assign rd_issue = bus.mem_en & ~bus.mem_we;

    // Hand-over sequencing; DRAIN and EXIT leave once nothing will be in flight
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:   if (boot_mode)  state_next = ST_DRAIN;
            ST_DRAIN: if (!rd_issue)  state_next = ST_BOOT;
            ST_BOOT:  if (!boot_mode) state_next = ST_EXIT;
            ST_EXIT:  if (!rd_issue)  state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    // State, fairness history and outstanding-read tracking
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            last_winner <= OWN_LDR;
            rd_pending  <= 1'b0;
            rd_owner    <= OWN_CPU;
        end else begin
            state      <= state_next;
            rd_pending <= rd_issue;
            if (rd_issue) begin
                rd_owner <= cpu_win ? OWN_CPU : OWN_LDR;
            end
            if (state == ST_EXIT && state_next == ST_RUN) begin
                last_winner <= OWN_LDR;
            end else if (cpu_win) begin
                last_winner <= OWN_CPU;
            end else if (ldr_win) begin
                last_winner <= OWN_LDR;
            end
        end
    end

    // Count loader writes accepted during the current boot session
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ldr_wr_count <= 16'd0;
        end else if (state == ST_DRAIN && state_next == ST_BOOT) begin
            ldr_wr_count <= 16'd0;
        end else if (state == ST_BOOT && ldr_win && bus.ldr_we) begin
            ldr_wr_count <= sat_inc16(ldr_wr_count);
        end
    end

    assign bus.cpu_gnt    = cpu_win;
    assign bus.ldr_gnt    = ldr_win;
    assign bus.cpu_rvalid = rd_pending && (rd_owner == OWN_CPU);
    assign bus.ldr_rvalid = rd_pending && (rd_owner == OWN_LDR);
    assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
    assign bus.ldr_rdata  = bus.ldr_rvalid ? bus.mem_rdata : '0;
    assign bus.cpu_stall  = (bus.cpu_req & ~cpu_win) | (state != ST_RUN);
    assign boot_active    = (state == ST_BOOT);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a table of single-cycle vectors for RUN
// arbitration and read return, then hand-written boot, reset and
// boot-toggle sequences. A small behavioural memory sits on the bus.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    typedef struct {
        logic              c_req;
        logic              c_we;
        logic [ADDR_W-1:0] c_addr;
        logic [DATA_W-1:0] c_wdata;
        logic              l_req;
        logic              l_we;
        logic [ADDR_W-1:0] l_addr;
        logic [DATA_W-1:0] l_wdata;
        logic              e_cgnt;
        logic              e_lgnt;
        logic              e_en;
        logic              e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wdata;
        logic              e_stall;
        logic              e_crv;
        logic [DATA_W-1:0] e_crdata;
        logic              e_lrv;
        logic [DATA_W-1:0] e_lrdata;
    } vec_t;

    logic        clock;
    logic        rst_n;
    logic        boot_mode;
    logic [15:0] ldr_wr_count;
    logic        boot_active;
    int          tests;
    int          failures;
    vec_t        vecs [14];
    logic [31:0] mem [0:255];

    dmem_arbiter_if bus ();

    dmem_arbiter dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .boot_mode    (boot_mode),
        .bus          (bus.slave),
        .ldr_wr_count (ldr_wr_count),
        .boot_active  (boot_active)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural single-port memory, read data one cycle after issue
    always @(posedge clock) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            mem[8'h10] <= 32'hDEADBEEF;
            mem[8'h11] <= 32'h11111111;
            mem[8'h30] <= 32'h30303030;
            bus.mem_rdata <= 32'd0;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr[7:0]];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd,
                         input logic lr, input logic lw, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld);
        bus.cpu_req   = cr;
        bus.cpu_we    = cw;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cd;
        bus.ldr_req   = lr;
        bus.ldr_we    = lw;
        bus.ldr_addr  = la;
        bus.ldr_wdata = ld;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        nextCycle();
        drive(v.c_req, v.c_we, v.c_addr, v.c_wdata, v.l_req, v.l_we, v.l_addr, v.l_wdata);
    endtask

    task automatic checkVector(input int i, input vec_t v);
        checkOutput($sformatf("v%0d cpu_gnt", i),    bus.cpu_gnt,    v.e_cgnt);
        checkOutput($sformatf("v%0d ldr_gnt", i),    bus.ldr_gnt,    v.e_lgnt);
        checkOutput($sformatf("v%0d mem_en", i),     bus.mem_en,     v.e_en);
        checkOutput($sformatf("v%0d mem_we", i),     bus.mem_we,     v.e_we);
        checkOutput($sformatf("v%0d mem_addr", i),   bus.mem_addr,   v.e_addr);
        checkOutput($sformatf("v%0d mem_wdata", i),  bus.mem_wdata,  v.e_wdata);
        checkOutput($sformatf("v%0d cpu_stall", i),  bus.cpu_stall,  v.e_stall);
        checkOutput($sformatf("v%0d cpu_rvalid", i), bus.cpu_rvalid, v.e_crv);
        checkOutput($sformatf("v%0d cpu_rdata", i),  bus.cpu_rdata,  v.e_crdata);
        checkOutput($sformatf("v%0d ldr_rvalid", i), bus.ldr_rvalid, v.e_lrv);
        checkOutput($sformatf("v%0d ldr_rdata", i),  bus.ldr_rdata,  v.e_lrdata);
        checkOutput($sformatf("v%0d boot_active", i), boot_active,   1'b0);
    endtask

    initial begin
        tests     = 0;
        failures  = 0;
        rst_n     = 1'b0;
        boot_mode = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        //           cpu: req we addr  wdata         ldr: req we addr  wdata         cgnt lgnt en we addr  wdata         stall crv crdata        lrv lrdata
        vecs[0]  = '{1'b0, 1'b0, 14'h00, 32'h0,         1'b0, 1'b0, 14'h00, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 14'h00, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 14'h10, 32'h0,         1'b0, 1'b0, 14'h00, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 14'h10, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 14'h00, 32'h0,         1'b0, 1'b0, 14'h00, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 14'h00, 32'h0,         1'b0, 1'b1, 32'hDEADBEEF,  1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 14'h11, 32'h0,         1'b1, 1'b0, 14'h30, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 14'h30, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 14'h11, 32'h0,         1'b1, 1'b0, 14'h30, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 14'h11, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h30303030};
        vecs[5]  = '{1'b1, 1'b0, 14'h11, 32'h0,         1'b1, 1'b0, 14'h30, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 14'h30, 32'h0,         1'b1, 1'b1, 32'h11111111,  1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 14'h11, 32'h0,         1'b1, 1'b0, 14'h30, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 14'h11, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h30303030};
        vecs[7]  = '{1'b0, 1'b0, 14'h00, 32'h0,         1'b1, 1'b1, 14'h20, 32'h12345678,  1'b0, 1'b1, 1'b1, 1'b1, 14'h20, 32'h12345678,  1'b0, 1'b1, 32'h11111111,  1'b0, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 14'h20, 32'h0,         1'b0, 1'b0, 14'h00, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 14'h20, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 14'h00, 32'h0,         1'b0, 1'b0, 14'h00, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 14'h00, 32'h0,         1'b0, 1'b1, 32'h12345678,  1'b0, 32'h0};
        vecs[10] = '{1'b1, 1'b1, 14'h40, 32'hCAFEF00D,  1'b1, 1'b0, 14'h10, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 14'h10, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 14'h40, 32'hCAFEF00D,  1'b0, 1'b0, 14'h00, 32'h0,         1'b1, 1'b0, 1'b1, 1'b1, 14'h40, 32'hCAFEF00D,  1'b0, 1'b0, 32'h0,         1'b1, 32'hDEADBEEF};
        vecs[12] = '{1'b0, 1'b0, 14'h00, 32'h0,         1'b1, 1'b0, 14'h40, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 14'h40, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[13] = '{1'b0, 1'b0, 14'h00, 32'h0,         1'b0, 1'b0, 14'h00, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 14'h00, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'hCAFEF00D};

        // Reset values while held in reset
        nextCycle();
        nextCycle();
        checkOutput("rst cpu_gnt",      bus.cpu_gnt,    1'b0);
        checkOutput("rst mem_en",       bus.mem_en,     1'b0);
        checkOutput("rst mem_addr",     bus.mem_addr,   14'h0);
        checkOutput("rst cpu_rvalid",   bus.cpu_rvalid, 1'b0);
        checkOutput("rst cpu_stall",    bus.cpu_stall,  1'b0);
        checkOutput("rst boot_active",  boot_active,    1'b0);
        checkOutput("rst ldr_wr_count", ldr_wr_count,   16'd0);
        rst_n = 1'b1;

        // Table-driven RUN-mode arbitration and read return
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clock);
            checkVector(i, vecs[i]);
        end

        // Boot hand-over: read granted as boot_mode rises, then loader writes
        nextCycle();
        boot_mode = 1'b1;
        drive(1, 0, 14'h10, 0, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("boot a0 cpu_gnt", bus.cpu_gnt, 1'b1);
        nextCycle();
        drive(1, 0, 14'h11, 0, 1, 1, 14'h50, 32'hB0000000);
        @(negedge clock);
        checkOutput("drain cpu_gnt",     bus.cpu_gnt,    1'b0);
        checkOutput("drain ldr_gnt",     bus.ldr_gnt,    1'b0);
        checkOutput("drain mem_en",      bus.mem_en,     1'b0);
        checkOutput("drain cpu_rvalid",  bus.cpu_rvalid, 1'b1);
        checkOutput("drain cpu_rdata",   bus.cpu_rdata,  32'hDEADBEEF);
        checkOutput("drain cpu_stall",   bus.cpu_stall,  1'b1);
        checkOutput("drain boot_active", boot_active,    1'b0);
        nextCycle();
        @(negedge clock);
        checkOutput("boot boot_active",  boot_active,    1'b1);
        checkOutput("boot cpu_gnt",      bus.cpu_gnt,    1'b0);
        checkOutput("boot ldr_gnt",      bus.ldr_gnt,    1'b1);
        checkOutput("boot mem_addr",     bus.mem_addr,   14'h50);
        checkOutput("boot cpu_stall",    bus.cpu_stall,  1'b1);
        checkOutput("boot count0",       ldr_wr_count,   16'd0);
        nextCycle();
        drive(1, 0, 14'h11, 0, 1, 1, 14'h51, 32'hB1111111);
        @(negedge clock);
        checkOutput("boot count1",       ldr_wr_count,   16'd1);
        checkOutput("boot w2 cpu_gnt",   bus.cpu_gnt,    1'b0);
        nextCycle();
        drive(1, 0, 14'h11, 0, 1, 1, 14'h52, 32'hB2222222);
        @(negedge clock);
        checkOutput("boot count2",       ldr_wr_count,   16'd2);
        nextCycle();
        boot_mode = 1'b0;
        drive(1, 0, 14'h11, 0, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("boot count3",       ldr_wr_count,   16'd3);
        checkOutput("boot last cpu_gnt", bus.cpu_gnt,    1'b0);
        checkOutput("boot last active",  boot_active,    1'b1);
        nextCycle();
        drive(1, 0, 14'h51, 0, 1, 0, 14'h52, 0);
        @(negedge clock);
        checkOutput("exit cpu_gnt",      bus.cpu_gnt,    1'b0);
        checkOutput("exit ldr_gnt",      bus.ldr_gnt,    1'b0);
        checkOutput("exit boot_active",  boot_active,    1'b0);
        checkOutput("exit cpu_stall",    bus.cpu_stall,  1'b1);
        nextCycle();
        @(negedge clock);
        checkOutput("run cpu_gnt",       bus.cpu_gnt,    1'b1);
        checkOutput("run ldr_gnt",       bus.ldr_gnt,    1'b0);
        checkOutput("run cpu_stall",     bus.cpu_stall,  1'b0);
        checkOutput("run count held",    ldr_wr_count,   16'd3);
        nextCycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("run cpu_rvalid",    bus.cpu_rvalid, 1'b1);
        checkOutput("run cpu_rdata",     bus.cpu_rdata,  32'hB1111111);

        // Reset the cycle after a granted read: response must be dropped
        nextCycle();
        drive(1, 0, 14'h10, 0, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("r0 cpu_gnt",        bus.cpu_gnt,    1'b1);
        nextCycle();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("mid rst cpu_rvalid", bus.cpu_rvalid, 1'b0);
        checkOutput("mid rst cpu_rdata",  bus.cpu_rdata,  32'h0);
        checkOutput("mid rst count",      ldr_wr_count,   16'd0);
        checkOutput("mid rst stall",      bus.cpu_stall,  1'b0);
        checkOutput("mid rst mem_en",     bus.mem_en,     1'b0);
        @(negedge clock);
        rst_n = 1'b1;
        nextCycle();
        drive(1, 0, 14'h11, 0, 1, 0, 14'h30, 0);
        @(negedge clock);
        checkOutput("post rst cpu_gnt",   bus.cpu_gnt,    1'b1);
        checkOutput("post rst ldr_gnt",   bus.ldr_gnt,    1'b0);
        checkOutput("post rst rvalid",    bus.cpu_rvalid, 1'b0);

        // boot_mode dropped during DRAIN still walks BOOT and EXIT, and the
        // exit restores CPU priority even though CPU won last
        nextCycle();
        boot_mode = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        boot_mode = 1'b0;
        @(negedge clock);
        checkOutput("tog drain active",  boot_active,    1'b0);
        checkOutput("tog drain stall",   bus.cpu_stall,  1'b1);
        nextCycle();
        @(negedge clock);
        checkOutput("tog boot active",   boot_active,    1'b1);
        nextCycle();
        @(negedge clock);
        checkOutput("tog exit active",   boot_active,    1'b0);
        checkOutput("tog exit stall",    bus.cpu_stall,  1'b1);
        nextCycle();
        drive(1, 0, 14'h11, 0, 1, 0, 14'h30, 0);
        @(negedge clock);
        checkOutput("tog run cpu_gnt",   bus.cpu_gnt,    1'b1);
        checkOutput("tog run ldr_gnt",   bus.ldr_gnt,    1'b0);
        nextCycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
